// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: fetch-side bus between the sequencer, the instruction ROM,
// the hazard/branch logic and the decode stage.
//   master : the fetch sequencer (drives rom_address, IF/ID and status)
//   slave  : the surrounding pipeline/ROM (drives stall, branch, rom_instr)
interface fetch_sequencer_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] rom_address;
  logic [31:0] rom_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
  logic        fault;
  logic        misalign;

  modport master (
    input  stall, branch_taken, branch_target, rom_instr,
    output rom_address, ifid_instr, ifid_pc4, ifid_valid, halted, fault, misalign
  );

  modport slave (
    output stall, branch_taken, branch_target, rom_instr,
    input  rom_address, ifid_instr, ifid_pc4, ifid_valid, halted, fault, misalign
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller. Owns the PC, addresses the ROM,
// registers each fetched word into IF/ID, and applies stall, branch redirect,
// halt and out-of-range fault.
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high
//   bus          fetch_sequencer_if.master (stall/branch in, ROM bus, IF/ID out,
//                halted/fault/misalign status)
//   fetch_count, stall_count, flush_count : saturating perf counters, present
//                only when FETCH_PERF_CNT_EN is defined
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int          ROM_BYTES   = 400,
  parameter logic [5:0]  HALT_OPCODE = 6'b101010
) (
  input  logic                      clock,
  input  logic                      reset,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]               fetch_count,
  output logic [31:0]               stall_count,
  output logic [15:0]               flush_count,
`endif
  fetch_sequencer_if.master         bus
);

  localparam logic [31:0] LAST_PC = 32'(ROM_BYTES - 4);

  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;

  state_t      state;
  logic [31:0] pc;

  assign bus.rom_address = pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      bus.ifid_instr <= 32'h0;
      bus.ifid_pc4   <= 32'h0;
      bus.ifid_valid <= 1'b0;
      bus.halted     <= 1'b0;
      bus.fault      <= 1'b0;
      bus.misalign   <= 1'b0;
    end else begin
      case (state)
        // ROM image finishes loading this cycle; IF/ID keeps its reset bubble.
        BOOT: state <= RUN;

        RUN: begin
          if (bus.branch_taken) begin
            // Branch wins over stall: the older instruction in EX must redirect.
            pc             <= {bus.branch_target[31:2], 2'b00};
            bus.ifid_instr <= 32'h0;
            bus.ifid_valid <= 1'b0;
            if (bus.branch_target[1:0] != 2'b00) bus.misalign <= 1'b1;
          end else if (!bus.stall) begin
            if (pc > LAST_PC) begin
              bus.ifid_instr <= 32'h0;
              bus.ifid_valid <= 1'b0;
              bus.fault      <= 1'b1;
              bus.halted     <= 1'b1;
              state          <= FAULT;
            end else begin
              bus.ifid_instr <= bus.rom_instr;
              bus.ifid_pc4   <= pc + 32'd4;
              bus.ifid_valid <= 1'b1;
              // Halt word is delivered to decode but the PC stays on it.
              if (bus.rom_instr[31:26] == HALT_OPCODE) begin
                bus.halted <= 1'b1;
                state      <= HALT;
              end else begin
                pc <= pc + 32'd4;
              end
            end
          end
        end

        HALT: begin
          if (bus.branch_taken) begin
            // A branch older than the halt word resolved late: resume fetching.
            pc             <= {bus.branch_target[31:2], 2'b00};
            bus.ifid_instr <= 32'h0;
            bus.ifid_valid <= 1'b0;
            if (bus.branch_target[1:0] != 2'b00) bus.misalign <= 1'b1;
            bus.halted     <= 1'b0;
            state          <= RUN;
          end else if (!bus.stall) begin
            bus.ifid_instr <= 32'h0;
            bus.ifid_valid <= 1'b0;
          end
        end

        // Terminal until reset; IF/ID was already bubbled on entry.
        FAULT: ;

        default: state <= BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic ev_fetch, ev_stall, ev_flush;

  assign ev_fetch = (state == RUN) && !bus.branch_taken && !bus.stall && (pc <= LAST_PC);
  assign ev_stall = (state == RUN) && bus.stall;
  assign ev_flush = ((state == RUN) || (state == HALT)) && bus.branch_taken;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
      flush_count <= 16'h0;
    end else begin
      if (ev_fetch && (fetch_count != '1)) fetch_count <= fetch_count + 32'd1;
      if (ev_stall && (stall_count != '1)) stall_count <= stall_count + 32'd1;
      if (ev_flush && (flush_count != '1)) flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench for fetch_sequencer. A 100-word ROM model
// (word i = 32'h1000_0000 | i, except word 0 and the halt word at byte 380)
// answers rom_address combinationally; outputs are sampled 1 time unit after
// each rising edge.
module tb_fetch_sequencer;
  logic clock = 1'b0;
  logic reset;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
  logic [15:0] flush_count;
`endif

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(32'd0), .ROM_BYTES(400), .HALT_OPCODE(6'b101010)) dut (
    .clock       (clock),
    .reset       (reset),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count (fetch_count),
    .stall_count (stall_count),
    .flush_count (flush_count),
`endif
    .bus         (bus)
  );

  always #5 clock = ~clock;

  logic [31:0] rom [0:127];

  always_comb begin
    bus.rom_instr = 32'h0;
    if (bus.rom_address < 32'd400) bus.rom_instr = rom[bus.rom_address[8:2]];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic branch(input logic [31:0] tgt, input logic st);
    bus.branch_taken  = 1'b1;
    bus.branch_target = tgt;
    bus.stall         = st;
    step();
    bus.branch_taken  = 1'b0;
    bus.stall         = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 32'h1000_0000 | 32'(i);
    rom[0]  = 32'h8001060A;
    rom[95] = 32'hA800FFFF;  // byte 380, opcode 101010

    reset = 1'b1;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'h0;
    step();
    step();
    check("rst_valid",    {31'b0, bus.ifid_valid}, 32'd0);
    check("rst_instr",    bus.ifid_instr, 32'h0);
    check("rst_pc4",      bus.ifid_pc4, 32'h0);
    check("rst_halted",   {31'b0, bus.halted}, 32'd0);
    check("rst_fault",    {31'b0, bus.fault}, 32'd0);
    check("rst_misalign", {31'b0, bus.misalign}, 32'd0);
    check("rst_addr",     bus.rom_address, 32'd0);

    // 1: BOOT cycle, then first fetch
    reset = 1'b0;
    step();
    check("boot_valid", {31'b0, bus.ifid_valid}, 32'd0);
    check("boot_addr",  bus.rom_address, 32'd0);
    step();
    check("f0_instr", bus.ifid_instr, 32'h8001060A);
    check("f0_pc4",   bus.ifid_pc4, 32'd4);
    check("f0_valid", {31'b0, bus.ifid_valid}, 32'd1);
    check("f0_addr",  bus.rom_address, 32'd4);

    // 2: stall 3 cycles at pc=12
    step();
    step();
    check("run_addr12", bus.rom_address, 32'd12);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_addr",  bus.rom_address, 32'd12);
      check("stall_pc4",   bus.ifid_pc4, 32'd12);
      check("stall_instr", bus.ifid_instr, 32'h1000_0002);
    end
    bus.stall = 1'b0;
    step();
    check("resume_pc4",   bus.ifid_pc4, 32'd16);
    check("resume_instr", bus.ifid_instr, 32'h1000_0003);

    // 3: branch with stall in the same cycle
    branch(32'd88, 1'b1);
    check("br_addr",  bus.rom_address, 32'd88);
    check("br_valid", {31'b0, bus.ifid_valid}, 32'd0);
    check("br_instr", bus.ifid_instr, 32'h0);
    step();
    check("br_fetch_instr", bus.ifid_instr, 32'h1000_0016);
    check("br_fetch_pc4",   bus.ifid_pc4, 32'd92);
    check("br_fetch_valid", {31'b0, bus.ifid_valid}, 32'd1);

    // 4: misaligned target, sticky through later branch
    branch(32'd91, 1'b0);
    check("mis_addr", bus.rom_address, 32'd88);
    check("mis_flag", {31'b0, bus.misalign}, 32'd1);
    branch(32'd200, 1'b0);
    check("mis_sticky", {31'b0, bus.misalign}, 32'd1);
    check("mis_addr2",  bus.rom_address, 32'd200);
    step();
    check("mis_fetch_pc4", bus.ifid_pc4, 32'd204);

    // 5: halt word at 380
    branch(32'd376, 1'b0);
    step();
    check("pre_halt_addr", bus.rom_address, 32'd380);
    step();
    check("halt_instr",  bus.ifid_instr, 32'hA800FFFF);
    check("halt_valid",  {31'b0, bus.ifid_valid}, 32'd1);
    check("halt_halted", {31'b0, bus.halted}, 32'd1);
    check("halt_addr",   bus.rom_address, 32'd380);
    step();
    check("halt_bubble", {31'b0, bus.ifid_valid}, 32'd0);
    check("halt_frozen", bus.rom_address, 32'd380);
    branch(32'd0, 1'b0);
    check("unhalt_halted", {31'b0, bus.halted}, 32'd0);
    check("unhalt_addr",   bus.rom_address, 32'd0);
    step();
    check("unhalt_fetch", bus.ifid_instr, 32'h8001060A);

    // 6: out-of-range fetch
    branch(32'd400, 1'b0);
    check("pre_fault_halted", {31'b0, bus.halted}, 32'd0);
    step();
    check("fault_flag",   {31'b0, bus.fault}, 32'd1);
    check("fault_halted", {31'b0, bus.halted}, 32'd1);
    check("fault_valid",  {31'b0, bus.ifid_valid}, 32'd0);
    branch(32'd0, 1'b0);
    check("fault_ign_addr", bus.rom_address, 32'd400);
    check("fault_ign_flag", {31'b0, bus.fault}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch", fetch_count, 32'd9);
    check("perf_stall", stall_count, 32'd4);
    check("perf_flush", {16'b0, flush_count}, 32'd6);
`endif

    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_fault",    {31'b0, bus.fault}, 32'd0);
    check("rst2_halted",   {31'b0, bus.halted}, 32'd0);
    check("rst2_misalign", {31'b0, bus.misalign}, 32'd0);
    check("rst2_addr",     bus.rom_address, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst2_perf_fetch", fetch_count, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
